// File: rtl/decode_pkg.sv
// Shared RV32I decode constants and the decoded control bundle used by decode_stage.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;
    localparam int FMT_W = 6;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [FMT_W-1:0] format;
        logic             rd_wen;
        logic             mem_wen;
        logic             mem_to_reg;
        logic             alu_src_1;
        logic             alu_src_2;
        logic             is_lui;
        logic [2:0]       opsel;
        logic             sub;
        logic             is_unsigned;
        logic             arith;
        logic             is_branch;
        logic             is_jal;
        logic             is_jalr;
        logic             is_load;
        logic [1:0]       mem_size;
        logic             load_unsigned;
        logic             illegal;
        logic             is_muldiv;
        logic [2:0]       muldiv_op;
    } decode_t;

endpackage

// File: rtl/inst_fifo.sv
// Circular instruction queue holding {pc, inst}; full queues refuse pushes even on a same-cycle pop.
module inst_fifo #(
    parameter int BUF_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [63:0] i_data,
    input  logic        i_pop,
    output logic [63:0] o_data,
    output logic        o_full,
    output logic        o_empty
);
    import decode_pkg::*;

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    logic [63:0]   mem [BUF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign o_full  = (count == FULL_CNT);
    assign o_empty = (count == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count/pointers alone decide which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (push_ok && !i_rst && !i_flush) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/decode_stage.sv
// Buffered RV32I decode stage with load-use bubble and flush.
// Optional RV32M decode is enabled by defining DECODE_RV32M_EN.
module decode_stage #(
    parameter int BUF_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_ready,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [5:0]  o_format,
    output logic        o_rd_wen,
    output logic        o_mem_wen,
    output logic        o_mem_to_reg,
    output logic        o_alu_src_1,
    output logic        o_alu_src_2,
    output logic        o_is_lui,
    output logic [2:0]  o_opsel,
    output logic        o_sub,
    output logic        o_unsigned,
    output logic        o_arith,
    output logic        o_is_branch,
    output logic        o_is_jal,
    output logic        o_is_jalr,
    output logic        o_is_load,
    output logic [1:0]  o_mem_size,
    output logic        o_load_unsigned,
    output logic        o_illegal,
    output logic        o_is_muldiv,
    output logic [2:0]  o_muldiv_op
);
    import decode_pkg::*;

    function automatic decode_t decode_inst(input logic [31:0] inst, input logic [31:0] pc);
        decode_t    d;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        // NOTE: full default first so no path through the case leaves a field unassigned (no latches).
        d      = '0;
        opcode = inst[6:0];
        funct3 = inst[14:12];
        funct7 = inst[31:25];
        d.inst = inst;
        d.pc   = pc;
        d.rs1  = inst[19:15];
        d.rs2  = inst[24:20];
        d.rd   = inst[11:7];
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
                    d.format[FMT_R] = 1'b1;
                    d.is_muldiv     = 1'b1;
                    d.muldiv_op     = funct3;
                    d.opsel         = funct3;
                    d.is_unsigned   = inst[12];
`else
                    d.illegal = 1'b1;
`endif
                end else if (funct7 == F7_BASE ||
                             (funct7 == F7_ALT && (funct3 == ALU_ADD || funct3 == ALU_SR))) begin
                    d.format[FMT_R] = 1'b1;
                    d.opsel         = funct3;
                    d.sub           = inst[30];
                    d.arith         = inst[30];
                    d.is_unsigned   = inst[12];
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if ((funct3 == ALU_SLL && funct7 != F7_BASE) ||
                    (funct3 == ALU_SR && funct7 != F7_BASE && funct7 != F7_ALT)) begin
                    d.illegal = 1'b1;
                end else begin
                    d.format[FMT_I] = 1'b1;
                    d.opsel         = funct3;
                    d.arith         = (funct3 == ALU_SR) && inst[30];
                    d.is_unsigned   = inst[12];
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    d.illegal = 1'b1;
                end else begin
                    d.format[FMT_I] = 1'b1;
                    d.is_load       = 1'b1;
                    d.mem_size      = funct3[1:0];
                    d.load_unsigned = funct3[2];
                end
            end
            OPC_STORE: begin
                if (funct3[2] || funct3 == 3'b011) begin
                    d.illegal = 1'b1;
                end else begin
                    d.format[FMT_S] = 1'b1;
                    d.mem_size      = funct3[1:0];
                end
            end
            OPC_BRANCH: begin
                if (funct3[2:1] == 2'b01) begin
                    d.illegal = 1'b1;
                end else begin
                    d.format[FMT_B] = 1'b1;
                    d.sub           = 1'b1;
                    d.is_unsigned   = inst[13];
                    d.opsel         = !funct3[2] ? ALU_ADD : (funct3[1] ? ALU_SLTU : ALU_SLT);
                end
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) begin
                    d.illegal = 1'b1;
                end else begin
                    d.format[FMT_I] = 1'b1;
                    d.is_jalr       = 1'b1;
                end
            end
            OPC_JAL: begin
                d.format[FMT_J] = 1'b1;
                d.is_jal        = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: d.format[FMT_U] = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        // Illegal paths never set a format bit, so every enable below falls to 0 for them.
        d.rd_wen     = (|d.format) && !d.format[FMT_S] && !d.format[FMT_B];
        d.mem_wen    = d.format[FMT_S];
        d.mem_to_reg = d.is_load;
        d.alu_src_1  = d.format[FMT_U];
        d.alu_src_2  = d.format[FMT_R] || d.format[FMT_B];
        d.is_lui     = d.format[FMT_U] && inst[5];
        d.is_branch  = d.format[FMT_B];
        return d;
    endfunction

    logic [63:0] head_data;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        hazard;
    logic        reads_rs1;
    logic        reads_rs2;
    logic        load_en;
    decode_t     head_dec;
    decode_t     out_q;
    logic        valid_q;

    assign o_ready = !full && !i_rst;
    assign push    = i_valid && o_ready && !i_flush;

    inst_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_push  (push),
        .i_data  ({i_pc, i_inst}),
        .i_pop   (pop),
        .o_data  (head_data),
        .o_full  (full),
        .o_empty (empty)
    );

    assign head_dec  = decode_inst(head_data[31:0], head_data[63:32]);
    assign reads_rs1 = head_dec.format[FMT_R] || head_dec.format[FMT_I] ||
                       head_dec.format[FMT_S] || head_dec.format[FMT_B];
    assign reads_rs2 = head_dec.format[FMT_R] || head_dec.format[FMT_S] || head_dec.format[FMT_B];

    // A load leaving this cycle whose rd the head consumes forces one bubble.
    assign hazard  = valid_q && i_ready && out_q.is_load && (out_q.rd != 5'd0) &&
                     ((reads_rs1 && head_dec.rs1 == out_q.rd) ||
                      (reads_rs2 && head_dec.rs2 == out_q.rd));
    assign load_en = (!valid_q || i_ready) && !empty && !hazard;
    assign pop     = load_en && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (load_en) begin
            out_q   <= head_dec;
            valid_q <= 1'b1;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid         = valid_q;
    assign o_inst          = out_q.inst;
    assign o_pc            = out_q.pc;
    assign o_rs1           = out_q.rs1;
    assign o_rs2           = out_q.rs2;
    assign o_rd            = out_q.rd;
    assign o_format        = out_q.format;
    assign o_rd_wen        = out_q.rd_wen;
    assign o_mem_wen       = out_q.mem_wen;
    assign o_mem_to_reg    = out_q.mem_to_reg;
    assign o_alu_src_1     = out_q.alu_src_1;
    assign o_alu_src_2     = out_q.alu_src_2;
    assign o_is_lui        = out_q.is_lui;
    assign o_opsel         = out_q.opsel;
    assign o_sub           = out_q.sub;
    assign o_unsigned      = out_q.is_unsigned;
    assign o_arith         = out_q.arith;
    assign o_is_branch     = out_q.is_branch;
    assign o_is_jal        = out_q.is_jal;
    assign o_is_jalr       = out_q.is_jalr;
    assign o_is_load       = out_q.is_load;
    assign o_mem_size      = out_q.mem_size;
    assign o_load_unsigned = out_q.load_unsigned;
    assign o_illegal       = out_q.illegal;
    assign o_is_muldiv     = out_q.is_muldiv;
    assign o_muldiv_op     = out_q.muldiv_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (BUF_DEPTH=4), hand-computed expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        ready, valid;
    logic [31:0] inst, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  format;
    logic        rd_wen, mem_wen, mem_to_reg, alu_src_1, alu_src_2, is_lui;
    logic [2:0]  opsel;
    logic        sub, is_unsigned, arith, is_branch, is_jal, is_jalr, is_load;
    logic [1:0]  mem_size;
    logic        load_unsigned, illegal, is_muldiv;
    logic [2:0]  muldiv_op;

    int checks = 0;
    int errors = 0;
    logic [31:0] seen [$];

    always #5 clk = ~clk;

    decode_stage #(.BUF_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid),
        .i_inst(in_inst), .i_pc(in_pc), .o_ready(ready), .o_valid(valid),
        .i_ready(out_ready), .o_inst(inst), .o_pc(pc), .o_rs1(rs1), .o_rs2(rs2),
        .o_rd(rd), .o_format(format), .o_rd_wen(rd_wen), .o_mem_wen(mem_wen),
        .o_mem_to_reg(mem_to_reg), .o_alu_src_1(alu_src_1), .o_alu_src_2(alu_src_2),
        .o_is_lui(is_lui), .o_opsel(opsel), .o_sub(sub), .o_unsigned(is_unsigned),
        .o_arith(arith), .o_is_branch(is_branch), .o_is_jal(is_jal),
        .o_is_jalr(is_jalr), .o_is_load(is_load), .o_mem_size(mem_size),
        .o_load_unsigned(load_unsigned), .o_illegal(illegal),
        .o_is_muldiv(is_muldiv), .o_muldiv_op(muldiv_op)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs set afterwards apply to the next edge, outputs are post-edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_inst  = i;
        in_pc    = p;
        step();
        in_valid = 1'b0;
    endtask

    // Consume with out_ready=1 for a bounded number of cycles, recording issued instructions.
    task automatic drain(input int cycles);
        seen.delete();
        out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (valid) seen.push_back(inst);
            step();
        end
    endtask

    function automatic logic [31:0] mk_addi(input int k);
        logic [11:0] imm;
        logic [4:0]  r;
        imm = 12'(k);
        r   = 5'(k);
        return {imm, 5'd0, 3'b000, r, 7'h13};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        step();
        check("rst_ready", ready, 0);
        check("rst_valid", valid, 0);
        check("rst_inst", inst, 0);
        rst = 1'b0;
        step();
        check("post_rst_ready", ready, 1);

        // add then addi streamed back-to-back
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h100;
        step();
        in_inst = 32'hFFF00293; in_pc = 32'h104;
        step();
        in_valid = 1'b0;
        check("add_valid", valid, 1);
        check("add_inst", inst, 32'h002081B3);
        check("add_format", format, 6'b000001);
        check("add_opsel", opsel, 0);
        check("add_sub", sub, 0);
        check("add_regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
        check("add_rd_wen", rd_wen, 1);
        check("add_alu_src_2", alu_src_2, 1);
        step();
        check("addi_valid", valid, 1);
        check("addi_pc", pc, 32'h104);
        check("addi_format", format, 6'b000010);
        check("addi_rd_wen", rd_wen, 1);
        check("addi_rd", rd, 5);
        step();
        check("idle_valid", valid, 0);

        // lw x6,0(x1) then add x7,x6,x2: one bubble
        in_valid = 1'b1; in_inst = 32'h0000A303; in_pc = 32'h200;
        step();
        in_inst = 32'h002303B3; in_pc = 32'h204;
        step();
        in_valid = 1'b0;
        check("lw_valid", valid, 1);
        check("lw_is_load", is_load, 1);
        check("lw_mem_to_reg", mem_to_reg, 1);
        check("lw_mem_size", mem_size, 2'b10);
        check("lw_rd", rd, 6);
        step();
        check("bubble_valid", valid, 0);
        step();
        check("dep_valid", valid, 1);
        check("dep_inst", inst, 32'h002303B3);
        step();

        // Fill with out_ready=0, refuse when full, pop one, push across wrap
        out_ready = 1'b0;
        push(mk_addi(10), 32'h300);
        step();
        check("fill_head_inst", inst, mk_addi(10));
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("fill_ready_%0d", k), ready, 1);
            push(mk_addi(10 + k), 32'h300 + 32'(4 * k));
        end
        check("full_ready", ready, 0);
        push(mk_addi(15), 32'h314);
        check("stall_valid", valid, 1);
        check("stall_inst", inst, mk_addi(10));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_ready", ready, 1);
        check("pop_inst", inst, mk_addi(11));
        push(mk_addi(16), 32'h318);
        check("refill_ready", ready, 0);
        drain(12);
        check("order_count", seen.size(), 5);
        if (seen.size() == 5) begin
            check("order_0", seen[0], mk_addi(11));
            check("order_1", seen[1], mk_addi(12));
            check("order_2", seen[2], mk_addi(13));
            check("order_3", seen[3], mk_addi(14));
            check("order_4", seen[4], mk_addi(16));
        end

        // Flush while full with output valid, then flush with a concurrent push
        out_ready = 1'b0;
        push(mk_addi(20), 32'h400);
        step();
        for (int k = 1; k <= 4; k++) push(mk_addi(20 + k), 32'h400 + 32'(4 * k));
        check("pre_flush_valid", valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_inst = mk_addi(30);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", valid, 0);
        check("flush_ready", ready, 1);
        flush = 1'b1; in_valid = 1'b1; in_inst = mk_addi(31);
        step();
        flush = 1'b0; in_valid = 1'b0;
        drain(6);
        check("flush_drop_count", seen.size(), 0);

        // Illegal, mul, bltu, lui queued then released one per cycle
        out_ready = 1'b0;
        push(32'h0000007F, 32'h500);
        push(32'h023100B3, 32'h504);
        push(32'h0020E463, 32'h508);
        push(32'h12345437, 32'h50C);
        check("ill_valid", valid, 1);
        check("ill_illegal", illegal, 1);
        check("ill_format", format, 0);
        check("ill_rd_wen", rd_wen, 0);
        out_ready = 1'b1;
        step();
        check("mul_inst", inst, 32'h023100B3);
`ifdef DECODE_RV32M_EN
        check("mul_is_muldiv", is_muldiv, 1);
        check("mul_op", muldiv_op, 3'b000);
        check("mul_illegal", illegal, 0);
        check("mul_rd_wen", rd_wen, 1);
`else
        check("mul_illegal", illegal, 1);
        check("mul_is_muldiv", is_muldiv, 0);
        check("mul_rd_wen", rd_wen, 0);
`endif
        step();
        check("bltu_format", format, 6'b001000);
        check("bltu_opsel", opsel, 3'b011);
        check("bltu_sub", sub, 1);
        check("bltu_unsigned", is_unsigned, 1);
        check("bltu_branch", is_branch, 1);
        check("bltu_rd_wen", rd_wen, 0);
        step();
        check("lui_format", format, 6'b010000);
        check("lui_is_lui", is_lui, 1);
        check("lui_alu_src_1", alu_src_1, 1);
        check("lui_rd_wen", rd_wen, 1);
        step();

        // Reset mid-stream
        out_ready = 1'b0;
        push(mk_addi(40), 32'h600);
        push(mk_addi(41), 32'h604);
        check("pre_rst_valid", valid, 1);
        rst = 1'b1; in_valid = 1'b1; in_inst = mk_addi(42);
        step();
        check("mid_rst_valid", valid, 0);
        check("mid_rst_inst", inst, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_format", format, 0);
        check("mid_rst_rd_wen", rd_wen, 0);
        check("mid_rst_ready", ready, 0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check("after_rst_ready", ready, 1);
        drain(6);
        check("after_rst_lost", seen.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
